// File: rtl/bf_pred_pkg.sv
// rtl/bf_pred_pkg.sv - shared helpers for the bias-free history and index generator
package bf_pred_pkg;

    // Upper bounds for the generic helpers: NUM_TABLES <= MAX_HIST, IDX_W <= MAX_IDX_W.
    localparam int MAX_HIST  = 64;
    localparam int MAX_IDX_W = 32;

    function automatic logic [MAX_IDX_W-1:0] sat_inc(input logic [MAX_IDX_W-1:0] v, input int w);
        logic [MAX_IDX_W-1:0] top;
        top = (MAX_IDX_W'(1) << w) - MAX_IDX_W'(1);
        return (v >= top) ? top : v + MAX_IDX_W'(1);
    endfunction

    // h[0] is the outcome of the most recent entry; bits beyond the history depth must be zero.
    function automatic logic [MAX_IDX_W-1:0] fold_hist(input logic [MAX_HIST-1:0] h,
                                                       input int shift, input int w);
        logic [MAX_HIST-1:0]  g;
        logic [MAX_IDX_W-1:0] mask;
        logic [MAX_IDX_W-1:0] acc;
        g    = h >> shift;
        mask = (MAX_IDX_W'(1) << w) - MAX_IDX_W'(1);
        acc  = '0;
        for (int c = 0; c < MAX_HIST; c++) begin
            acc = acc ^ (g[MAX_IDX_W-1:0] & mask);
            g   = g >> w;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bf_ghist_reg.sv
// rtl/bf_ghist_reg.sv - one copy of the bias-free history with push and bulk-load ports
module bf_ghist_reg
    import bf_pred_pkg::*;
#(
    parameter int NUM_TABLES  = 48,
    parameter int IDX_W       = 16,
    parameter int POS_W       = 6,
    parameter bit EXPOSE_NEXT = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push_i,
    input  logic                                 taken_i,
    input  logic                                 biased_i,
    input  logic [IDX_W-1:0]                     addr_i,
    input  logic                                 load_i,
    input  logic [NUM_TABLES*(IDX_W+POS_W+2)-1:0] load_hist_i,
    output logic [NUM_TABLES*(IDX_W+POS_W+2)-1:0] hist_o
);

    typedef struct packed {
        logic             vld;
        logic             taken;
        logic [IDX_W-1:0] addr;
        logic [POS_W-1:0] pos;
    } entry_t;

    entry_t [NUM_TABLES-1:0] hist_q;
    entry_t [NUM_TABLES-1:0] hist_d;
    entry_t [NUM_TABLES-1:0] load_e;

    // Empty entries stay all-zero so a copy can be loaded verbatim from the other one.
    function automatic entry_t age(input entry_t e);
        entry_t r;
        r = e;
        if (e.vld) begin
            r.pos = POS_W'(sat_inc(MAX_IDX_W'(e.pos), POS_W));
        end
        return r;
    endfunction

    assign load_e = load_hist_i;

    always_comb begin
        hist_d = hist_q;
        if (load_i) begin
            hist_d = load_e;
        end else if (push_i) begin
            if (biased_i) begin
                for (int i = 0; i < NUM_TABLES; i++) begin
                    hist_d[i] = age(hist_q[i]);
                end
            end else begin
                for (int i = 1; i < NUM_TABLES; i++) begin
                    hist_d[i] = age(hist_q[i-1]);
                end
                hist_d[0].vld   = 1'b1;
                hist_d[0].taken = taken_i;
                hist_d[0].addr  = addr_i;
                hist_d[0].pos   = POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // The committed copy exposes its next state so a flush sees this cycle's commit.
    assign hist_o = EXPOSE_NEXT ? hist_d : hist_q;

endmodule

// File: rtl/bf_index_pipe.sv
// rtl/bf_index_pipe.sv - two-stage pipelined bias-free perceptron index generator
module bf_index_pipe
    import bf_pred_pkg::*;
#(
    parameter int NUM_TABLES = 48,
    parameter int IDX_W      = 16,
    parameter int POS_W      = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pred_valid,
    input  logic [IDX_W-1:0]            pred_pc,
    input  logic                        stall,
    output logic                        idx_valid,
    output logic [NUM_TABLES*IDX_W-1:0] idx,
    input  logic                        spec_push,
    input  logic                        spec_taken,
    input  logic                        spec_biased,
    input  logic [IDX_W-1:0]            spec_addr,
    input  logic                        commit_push,
    input  logic                        commit_taken,
    input  logic                        commit_biased,
    input  logic [IDX_W-1:0]            commit_addr,
    input  logic                        flush
);

    localparam int EW = IDX_W + POS_W + 2;

    typedef struct packed {
        logic             vld;
        logic             taken;
        logic [IDX_W-1:0] addr;
        logic [POS_W-1:0] pos;
    } entry_t;

    logic [NUM_TABLES*EW-1:0] spec_hist;
    logic [NUM_TABLES*EW-1:0] commit_next;
    entry_t [NUM_TABLES-1:0]  spec_e;

    bf_ghist_reg #(
        .NUM_TABLES (NUM_TABLES),
        .IDX_W      (IDX_W),
        .POS_W      (POS_W),
        .EXPOSE_NEXT(1'b1)
    ) u_commit (
        .clk        (clk),
        .rst        (rst),
        .push_i     (commit_push),
        .taken_i    (commit_taken),
        .biased_i   (commit_biased),
        .addr_i     (commit_addr),
        .load_i     (1'b0),
        .load_hist_i('0),
        .hist_o     (commit_next)
    );

    bf_ghist_reg #(
        .NUM_TABLES (NUM_TABLES),
        .IDX_W      (IDX_W),
        .POS_W      (POS_W),
        .EXPOSE_NEXT(1'b0)
    ) u_spec (
        .clk        (clk),
        .rst        (rst),
        .push_i     (spec_push & ~flush),
        .taken_i    (spec_taken),
        .biased_i   (spec_biased),
        .addr_i     (spec_addr),
        .load_i     (flush),
        .load_hist_i(commit_next),
        .hist_o     (spec_hist)
    );

    assign spec_e = spec_hist;

    logic [MAX_HIST-1:0]                  hvec;
    logic [NUM_TABLES-1:0][IDX_W-1:0]     ap;
    logic [NUM_TABLES-1:0][IDX_W-1:0]     fd;

    always_comb begin
        hvec = '0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            hvec[i] = spec_e[i].vld & spec_e[i].taken;
        end
        for (int m = 0; m < NUM_TABLES; m++) begin
            ap[m] = spec_e[m].addr ^ IDX_W'(spec_e[m].pos);
            fd[m] = IDX_W'(fold_hist(hvec, m, IDX_W));
        end
    end

    logic                             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]                 s1_pc_q, s1_pc_d;
    logic [NUM_TABLES-1:0][IDX_W-1:0] s1_ap_q, s1_ap_d;
    logic [NUM_TABLES-1:0][IDX_W-1:0] s1_fold_q, s1_fold_d;
    logic                             idx_valid_q, idx_valid_d;
    logic [NUM_TABLES-1:0][IDX_W-1:0] idx_q, idx_d;

    // Stall freezes both stages; a request presented during stall is simply not taken.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pc_d     = s1_pc_q;
        s1_ap_d     = s1_ap_q;
        s1_fold_d   = s1_fold_q;
        idx_valid_d = idx_valid_q;
        idx_d       = idx_q;
        if (!stall) begin
            s1_valid_d  = pred_valid;
            idx_valid_d = s1_valid_q;
            if (pred_valid) begin
                s1_pc_d   = pred_pc;
                s1_ap_d   = ap;
                s1_fold_d = fd;
            end
            if (s1_valid_q) begin
                for (int m = 0; m < NUM_TABLES; m++) begin
                    idx_d[m] = s1_pc_q ^ s1_ap_q[m] ^ s1_fold_q[m];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_pc_q     <= '0;
            s1_ap_q     <= '0;
            s1_fold_q   <= '0;
            idx_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pc_q     <= s1_pc_d;
            s1_ap_q     <= s1_ap_d;
            s1_fold_q   <= s1_fold_d;
            idx_valid_q <= idx_valid_d;
            idx_q       <= idx_d;
        end
    end

    assign idx_valid = idx_valid_q;
    assign idx       = idx_q;

endmodule

// File: tb/tb_bf_index_pipe.sv
// tb/tb_bf_index_pipe.sv - directed bench for bf_index_pipe
module tb_bf_index_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        pred_valid = 1'b0;
    logic [3:0]  pred_pc = 4'h0;
    logic        stall = 1'b0;
    logic        idx_valid;
    logic [15:0] idx;
    logic        spec_push = 1'b0, spec_taken = 1'b0, spec_biased = 1'b0;
    logic [3:0]  spec_addr = 4'h0;
    logic        commit_push = 1'b0, commit_taken = 1'b0, commit_biased = 1'b0;
    logic [3:0]  commit_addr = 4'h0;
    logic        flush = 1'b0;

    logic        p2_valid = 1'b0;
    logic [3:0]  p2_pc = 4'h0;
    logic        s2_push = 1'b0, s2_taken = 1'b0, s2_biased = 1'b0;
    logic [3:0]  s2_addr = 4'h0;
    logic        zb = 1'b0;
    logic [3:0]  z4 = 4'h0;
    logic        idx2_valid;
    logic [31:0] idx2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bf_index_pipe #(.NUM_TABLES(4), .IDX_W(4), .POS_W(3)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .stall(stall),
        .idx_valid(idx_valid), .idx(idx),
        .spec_push(spec_push), .spec_taken(spec_taken), .spec_biased(spec_biased), .spec_addr(spec_addr),
        .commit_push(commit_push), .commit_taken(commit_taken), .commit_biased(commit_biased),
        .commit_addr(commit_addr), .flush(flush)
    );

    bf_index_pipe #(.NUM_TABLES(8), .IDX_W(4), .POS_W(3)) dut8 (
        .clk(clk), .rst(rst),
        .pred_valid(p2_valid), .pred_pc(p2_pc), .stall(zb),
        .idx_valid(idx2_valid), .idx(idx2),
        .spec_push(s2_push), .spec_taken(s2_taken), .spec_biased(s2_biased), .spec_addr(s2_addr),
        .commit_push(zb), .commit_taken(zb), .commit_biased(zb),
        .commit_addr(z4), .flush(zb)
    );

    typedef struct {
        logic        s_push;
        logic        s_taken;
        logic        s_biased;
        logic [3:0]  s_addr;
        int          reps;
        logic [3:0]  pc;
        logic [15:0] exp_idx;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic predict(input logic [3:0] pc, input logic [15:0] exp, input string name);
        pred_valid = 1'b1;
        pred_pc    = pc;
        step();
        pred_valid = 1'b0;
        step();
        check({name, "_valid"}, 32'(idx_valid), 32'd1);
        check({name, "_idx"}, 32'(idx), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 0, 4'hA, 16'hAAAA};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 4'h3, 1, 4'h0, 16'h0003};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 1, 4'h0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 4'h0, 8, 4'h0, 16'h0005};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 0, 4'hF, 16'hFFFA};

        step();
        step();
        rst = 1'b0;
        check("reset_valid", 32'(idx_valid), 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        check("reset_valid8", 32'(idx2_valid), 32'd0);

        // Eight-table config: eight taken pushes with addr 0.
        for (int i = 0; i < 8; i++) begin
            s2_push = 1'b1; s2_taken = 1'b1; s2_biased = 1'b0; s2_addr = 4'h0;
            step();
        end
        s2_push  = 1'b0;
        p2_valid = 1'b1;
        p2_pc    = 4'h0;
        step();
        p2_valid = 1'b0;
        step();
        check("n8_valid", 32'(idx2_valid), 32'd1);
        check("n8_idx1", 32'(idx2[3:0]), 32'h1);
        check("n8_idx2", 32'(idx2[7:4]), 32'hA);
        check("n8_all", idx2, 32'h641AAFA1);

        for (int v = 0; v < 5; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                spec_push   = vecs[v].s_push;
                spec_taken  = vecs[v].s_taken;
                spec_biased = vecs[v].s_biased;
                spec_addr   = vecs[v].s_addr;
                step();
            end
            spec_push = 1'b0;
            predict(vecs[v].pc, vecs[v].exp_idx, $sformatf("vec%0d", v));
        end

        // Reset while a request sits in S1.
        pred_valid = 1'b1;
        pred_pc    = 4'h5;
        step();
        pred_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_async_valid", 32'(idx_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("midrst_valid_a", 32'(idx_valid), 32'd0);
        step();
        check("midrst_valid_b", 32'(idx_valid), 32'd0);
        check("midrst_idx", 32'(idx), 32'd0);

        // Push and request in the same cycle, then a back-to-back request.
        spec_push = 1'b1; spec_taken = 1'b1; spec_biased = 1'b0; spec_addr = 4'h3;
        pred_valid = 1'b1; pred_pc = 4'h0;
        step();
        spec_push = 1'b0;
        step();
        pred_valid = 1'b0;
        check("same_valid", 32'(idx_valid), 32'd1);
        check("same_idx", 32'(idx), 32'h0000);
        step();
        check("next_valid", 32'(idx_valid), 32'd1);
        check("next_idx", 32'(idx), 32'h0003);
        step();
        check("b2b_done_valid", 32'(idx_valid), 32'd0);

        // Flush restores from the (empty) committed copy; a same-cycle spec push is ignored.
        spec_push = 1'b1; spec_taken = 1'b1; spec_biased = 1'b0; spec_addr = 4'h5;
        step();
        spec_taken = 1'b0; spec_addr = 4'h9;
        step();
        spec_taken = 1'b1; spec_addr = 4'h7;
        flush = 1'b1;
        step();
        spec_push = 1'b0;
        flush = 1'b0;
        predict(4'h0, 16'h0000, "flush_empty");
        flush = 1'b1;
        commit_push = 1'b1; commit_taken = 1'b1; commit_biased = 1'b0; commit_addr = 4'h3;
        step();
        flush = 1'b0;
        commit_push = 1'b0;
        predict(4'h0, 16'h0003, "flush_commit");

        // Stall holds S2 and drops requests presented meanwhile.
        rst = 1'b1;
        step();
        rst = 1'b0;
        pred_valid = 1'b1;
        pred_pc    = 4'h7;
        step();
        pred_valid = 1'b0;
        step();
        check("stall_pre_valid", 32'(idx_valid), 32'd1);
        check("stall_pre_idx", 32'(idx), 32'h7777);
        stall = 1'b1;
        pred_valid = 1'b1;
        pred_pc = 4'h2;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall_hold_valid%0d", c), 32'(idx_valid), 32'd1);
            check($sformatf("stall_hold_idx%0d", c), 32'(idx), 32'h7777);
        end
        stall = 1'b0;
        pred_valid = 1'b0;
        step();
        check("stall_rel_valid_a", 32'(idx_valid), 32'd0);
        step();
        check("stall_rel_valid_b", 32'(idx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
